// File: rtl/rv32_lsu_if.sv
// rv32_lsu_if: request/response handshake and data-memory port bundle for rv32_lsu.
// The slave modport is the LSU view; the master modport is the pipeline + memory view.
interface rv32_lsu_if;
  // MEM-stage request
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  // MEM-stage response
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  // Word-addressed data memory port
  logic        mem_enable;
  logic        mem_read;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata,
    output req_ready,
    output resp_valid, resp_rdata, resp_err,
    input  resp_ready,
    output mem_enable, mem_read, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_err,
    output resp_ready,
    input  mem_enable, mem_read, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/rv32_lsu.sv
// rv32_lsu: single-outstanding RV32 load/store unit in front of a word-addressed
// data memory without byte enables. Sub-word stores use read-modify-write.
// Optional feature: define LSU_BOUNDS_CHECK_EN to flag word indices >= MEM_WORDS
// as errors (no memory access, response one cycle after accept).
module rv32_lsu #(
  parameter int unsigned MEM_WORDS = 256
) (
  input logic        clk,
  input logic        rst,
  rv32_lsu_if.slave  bus
);

`ifdef LSU_BOUNDS_CHECK_EN
  localparam bit LP_BOUNDS_EN = 1'b1;
`else
  localparam bit LP_BOUNDS_EN = 1'b0;
`endif
  localparam logic [29:0] LP_WORDS = 30'(MEM_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_CAPTURE,
    S_WRITE,
    S_RESP
  } state_t;

  state_t      r_state;
  logic        r_req_ready;
  logic        r_resp_valid;
  logic        r_resp_err;
  logic [31:0] r_resp_rdata;
  logic        r_mem_enable;
  logic        r_mem_read;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic        r_store;
  logic [2:0]  r_funct3;
  logic [1:0]  r_addr_lo;
  logic [15:0] r_wdata_lo;

  logic        w_accept;
  logic        w_bad_f3;
  logic        w_misalign;
  logic        w_oob;
  logic        w_req_err;
  logic [4:0]  w_shamt;
  logic [31:0] w_lane;
  logic [31:0] w_load;
  logic [31:0] w_mask;
  logic [31:0] w_ins;
  logic [31:0] w_merge;

  assign bus.req_ready  = r_req_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_err   = r_resp_err;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.mem_enable = r_mem_enable;
  assign bus.mem_read   = r_mem_read;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;

  assign w_accept = bus.req_valid & r_req_ready;

  // Classify the incoming request: illegal funct3, misalignment, out-of-range word.
  always_comb begin
    w_bad_f3   = 1'b0;
    w_misalign = 1'b0;
    case (bus.req_funct3)
      3'b000: w_misalign = 1'b0;
      3'b001: w_misalign = bus.req_addr[0];
      3'b010: w_misalign = |bus.req_addr[1:0];
      3'b100, 3'b101: begin
        w_bad_f3   = bus.req_store;
        w_misalign = bus.req_funct3[0] & bus.req_addr[0];
      end
      default: w_bad_f3 = 1'b1;
    endcase
    w_oob     = (bus.req_addr[31:2] >= LP_WORDS);
    w_req_err = w_bad_f3 | w_misalign | (LP_BOUNDS_EN & w_oob);
  end

  // Lane extraction with sign/zero extension for loads (byte offset 0 for words).
  always_comb begin
    w_shamt = 5'({r_addr_lo, 3'b000});
    w_lane  = bus.mem_rdata >> w_shamt;
    case (r_funct3)
      3'b000:  w_load = {{24{w_lane[7]}}, w_lane[7:0]};
      3'b100:  w_load = {24'h0, w_lane[7:0]};
      3'b001:  w_load = {{16{w_lane[15]}}, w_lane[15:0]};
      3'b101:  w_load = {16'h0, w_lane[15:0]};
      default: w_load = w_lane;
    endcase
  end

  // Insert store byte/half into the fetched word for read-modify-write.
  always_comb begin
    w_mask  = (r_funct3[0] ? 32'h0000_FFFF : 32'h0000_00FF) << w_shamt;
    w_ins   = 32'({16'h0, r_wdata_lo}) << w_shamt;
    w_merge = (bus.mem_rdata & ~w_mask) | (w_ins & w_mask);
  end

  // Control FSM; every bus-facing output is a register updated on the transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= 32'h0;
      r_mem_enable <= 1'b0;
      r_mem_read   <= 1'b1;
      r_mem_addr   <= 32'h0;
      r_mem_wdata  <= 32'h0;
      r_store      <= 1'b0;
      r_funct3     <= 3'b000;
      r_addr_lo    <= 2'b00;
      r_wdata_lo   <= 16'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_req_ready <= 1'b0;
            r_store     <= bus.req_store;
            r_funct3    <= bus.req_funct3;
            r_addr_lo   <= bus.req_addr[1:0];
            r_wdata_lo  <= bus.req_wdata[15:0];
            r_mem_addr  <= {2'b00, bus.req_addr[31:2]};
            if (w_req_err) begin
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= 32'h0;
              r_state      <= S_RESP;
            end else if (bus.req_store && (bus.req_funct3 == 3'b010)) begin
              r_mem_read  <= 1'b0;
              r_mem_wdata <= bus.req_wdata;
              r_state     <= S_WRITE;
            end else begin
              r_mem_enable <= 1'b1;
              r_state      <= S_RD_ISSUE;
            end
          end
        end
        S_RD_ISSUE: r_state <= S_RD_WAIT;
        S_RD_WAIT:  r_state <= S_CAPTURE;
        S_CAPTURE: begin
          r_mem_enable <= 1'b0;
          if (r_store) begin
            r_mem_wdata <= w_merge;
            r_mem_read  <= 1'b0;
            r_state     <= S_WRITE;
          end else begin
            r_resp_rdata <= w_load;
            r_resp_err   <= 1'b0;
            r_resp_valid <= 1'b1;
            r_state      <= S_RESP;
          end
        end
        S_WRITE: begin
          r_mem_read   <= 1'b1;
          r_resp_rdata <= 32'h0;
          r_resp_err   <= 1'b0;
          r_resp_valid <= 1'b1;
          r_state      <= S_RESP;
        end
        S_RESP: begin
          if (bus.resp_ready) begin
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= 32'h0;
            r_req_ready  <= 1'b1;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_req_ready  <= 1'b1;
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
          r_mem_enable <= 1'b0;
          r_mem_read   <= 1'b1;
        end
      endcase
    end
  end

endmodule
